intt_stream: RTL and testbench

Streaming inverse number-theoretic transform. It is the inverse counterpart of the forward `ntt` matrix-vector engine: it consumes the N evaluation-domain words that `ntt` produces and returns the coefficient-domain vector. Each row keeps a running modular accumulator and a running twiddle power, so input words are absorbed one per cycle. The block sits after `ntt` in the zk-SNARK polynomial pipeline, where outputs are streamed to downstream consumers over a valid/ready handshake.

---
 rtl/intt_stream.sv | 158 +++++++++++++++
 tb/tb_intt_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_stream.sv
// Streaming inverse NTT: one input word per cycle folded into N row accumulators, then rows streamed out.
// Optional macro INTT_SCALE_EN adds a SCALE state that multiplies every row by NINV before output.
module intt_stream #(
  parameter int N = 64,
  parameter int W = 64,
  parameter logic [W-1:0] Q    = W'(257),
  parameter logic [W-1:0] WINV = W'(165),
  parameter logic [W-1:0] NINV = W'(253),
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          done,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a word moves on a port only in a cycle where valid && ready are both high at posedge clk.

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SCALE = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, Q};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] addmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  // Row i advances its twiddle by WINV^i per accepted word.
  function automatic logic [N*W-1:0] step_table();
    logic [N*W-1:0] t;
    logic [W-1:0]   cur;
    t   = '0;
    cur = W'(1);
    for (int i = 0; i < N; i++) begin
      t[i*W +: W] = cur;
      cur = mulmod(cur, WINV);
    end
    return t;
  endfunction

  localparam logic [N*W-1:0] STEPS = step_table();

  state_t          state_q, state_d;
  logic [IW-1:0]   j_q, k_q;
  logic            done_q;
  logic [W-1:0]    acc_q [N];
  logic [W-1:0]    pw_q  [N];
  logic [W-1:0]    x_red;
  logic            in_fire, out_fire;

  assign x_red       = in_data % Q;
  assign in_ready    = (state_q == S_LOAD) && !rst;
  assign out_valid   = (state_q == S_EMIT) && !rst;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign out_data    = out_valid ? acc_q[k_q] : '0;
  assign out_idx     = out_valid ? k_q : '0;
  assign done        = done_q && !rst;
  assign dbg_state_o = state_q;

`ifndef INTT_SCALE_EN
  logic unused_ninv;
  assign unused_ninv = ^NINV;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire && (j_q == LAST)) begin
`ifdef INTT_SCALE_EN
          state_d = S_SCALE;
`else
          state_d = S_EMIT;
`endif
        end
      end
`ifdef INTT_SCALE_EN
      S_SCALE: state_d = S_EMIT;
`endif
      S_EMIT: begin
        if (out_fire && (k_q == LAST)) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= '0;
        pw_q[i]  <= W'(1);
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            j_q <= (j_q == LAST) ? '0 : j_q + 1'b1;
            for (int i = 0; i < N; i++) begin
              acc_q[i] <= addmod(acc_q[i], mulmod(x_red, pw_q[i]));
              pw_q[i]  <= mulmod(pw_q[i], STEPS[i*W +: W]);
            end
          end
        end
`ifdef INTT_SCALE_EN
        S_SCALE: begin
          k_q <= '0;
          for (int i = 0; i < N; i++) acc_q[i] <= mulmod(acc_q[i], NINV);
        end
`endif
        S_EMIT: begin
          if (out_fire) begin
            if (k_q == LAST) begin
              // Leave the rows ready for the next transform.
              k_q    <= '0;
              j_q    <= '0;
              done_q <= 1'b1;
              for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
                pw_q[i]  <= W'(1);
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_stream.sv
// Bench for intt_stream: small N=4/Q=17 instance for directed scenarios, default N=64/Q=257 instance for round trip.
module tb_intt_stream;

`ifdef INTT_SCALE_EN
  localparam int LAT    = 2;
  localparam bit SCALED = 1'b1;
`else
  localparam int LAT    = 1;
  localparam bit SCALED = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance
  logic        in_valid, in_ready, out_valid, out_ready, done;
  logic [15:0] in_data, out_data;
  logic [1:0]  out_idx, dbg_state;

  intt_stream #(.N(4), .W(16), .Q(16'd17), .WINV(16'd13), .NINV(16'd13)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done), .dbg_state_o(dbg_state)
  );

  // default instance
  logic        in_valid2, in_ready2, out_valid2, out_ready2, done2;
  logic [63:0] in_data2, out_data2;
  logic [5:0]  out_idx2;
  logic [1:0]  dbg_state2;

  intt_stream dut_big (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_idx(out_idx2), .done(done2), .dbg_state_o(dbg_state2)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int last_in_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_data = '0;
  logic [1:0]  prev_idx = '0;
  logic [31:0] mon_e, mon_e2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (done) begin
        done_cnt++;
        check("in_ready_with_done", in_ready, 1);
      end
      if (out_valid) begin
        check("in_ready_in_emit", in_ready, 0);
        check("done_with_valid", done, 0);
        if (!prev_valid) check("latency", cyc - last_in_cyc, LAT);
        if (prev_valid && !prev_ready) begin
          check("hold_data", out_data, prev_data);
          check("hold_idx", out_idx, prev_idx);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) flag("unexpected_output");
          else begin
            mon_e = exp_q.pop_front();
            check("out_data", out_data, mon_e[15:0]);
            check("out_idx", out_idx, mon_e[17:16]);
          end
        end
      end
      if (done2) done2_cnt++;
      if (out_valid2 && out_ready2) begin
        if (exp2_q.size() == 0) flag("unexpected_output_big");
        else begin
          mon_e2 = exp2_q.pop_front();
          check("big_out_data", out_data2, mon_e2[15:0]);
          check("big_out_idx", out_idx2, mon_e2[21:16]);
        end
      end
    end
    prev_valid = out_valid && !rst;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_idx   = out_idx;
  end

  // driver tasks
  task automatic push4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    exp_q.push_back({16'd0, a});
    exp_q.push_back({16'd1, b});
    exp_q.push_back({16'd2, c});
    exp_q.push_back({16'd3, d});
  endtask

  task automatic send(input logic [15:0] x);
    int t = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) flag("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [63:0] x);
    int t = 0;
    in_valid2 = 1'b1;
    in_data2  = x;
    @(negedge clk);
    while (!in_ready2 && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready2) flag("send2_timeout");
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic drain_small(input int exp_done);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      flag("drain_timeout");
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, exp_done);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_big(input int exp_done);
    int t = 0;
    while (exp2_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp2_q.size() != 0) begin
      flag("drain_big_timeout");
      exp2_q.delete();
    end
    repeat (3) @(negedge clk);
    check("big_done_count", done2_cnt, exp_done);
    @(posedge clk);
    #1;
  endtask

  // hand-computed expectations for the small instance
  logic [15:0] imp0, dcv;
  longint unsigned cvec [64];
  longint unsigned xvec [64];

  initial begin
    longint unsigned wj, p, s;
    int t;
    imp0 = SCALED ? 16'd1 : 16'd4;
    dcv  = SCALED ? 16'd13 : 16'd1;
    in_valid = 0; in_data = '0; out_ready = 1;
    in_valid2 = 0; in_data2 = '0; out_ready2 = 1;
    rst = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_done", done, 0);
    check("rst_big_in_ready", in_ready2, 0);
    check("rst_big_out_valid", out_valid2, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    check("out_valid_after_reset", out_valid, 0);
    @(posedge clk);
    #1;

    // impulse
    push4(imp0, 16'd0, 16'd0, 16'd0);
    repeat (4) send(16'd1);
    drain_small(1);

    // dc
    push4(dcv, dcv, dcv, dcv);
    send(16'd1); send(16'd0); send(16'd0); send(16'd0);
    drain_small(2);

    // input gaps and output backpressure
    push4(imp0, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      send(16'd1);
      @(posedge clk);
      #1;
    end
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!out_valid) flag("bp_wait_valid");
    @(posedge clk);
    #1 out_ready = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    drain_small(3);

    // abort mid-load
    send(16'd1);
    send(16'd1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    check("no_done_after_abort", done_cnt, 3);
    @(posedge clk);
    #1;
    push4(dcv, dcv, dcv, dcv);
    send(16'd1); send(16'd0); send(16'd0); send(16'd0);
    drain_small(4);

    // back-to-back transforms
    push4(imp0, 16'd0, 16'd0, 16'd0);
    push4(dcv, dcv, dcv, dcv);
    repeat (4) send(16'd1);
    send(16'd1); send(16'd0); send(16'd0); send(16'd0);
    drain_small(6);

    // round trip on the default instance: forward NTT with root 81
    for (int i = 0; i < 64; i++) cvec[i] = longint'($urandom_range(0, 256));
    wj = 1;
    for (int j = 0; j < 64; j++) begin
      s = 0;
      p = 1;
      for (int i = 0; i < 64; i++) begin
        s = (s + cvec[i] * p) % 257;
        p = (p * wj) % 257;
      end
      xvec[j] = s;
      wj = (wj * 81) % 257;
    end
    for (int k = 0; k < 64; k++) begin
      s = SCALED ? cvec[k] : (64 * cvec[k]) % 257;
      exp2_q.push_back({10'd0, 6'(k), 16'(s)});
    end
    for (int j = 0; j < 64; j++) send2(64'(xvec[j]));
    drain_big(1);

    // out-of-range input word 300 is reduced to 43
    for (int k = 0; k < 64; k++) exp2_q.push_back({10'd0, 6'(k), (SCALED ? 16'd85 : 16'd43)});
    send2(64'd300);
    repeat (63) send2(64'd0);
    drain_big(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
